// File: rtl/x_window_buffer_pkg.sv
// Shared types and width helpers for the multi-lane X-operand window buffer.
package x_buf_pkg;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } buf_state_e;

  // Element counter must hold LANES*DEPTH itself (saturation value).
  function automatic int CNT_W(input int lanes, input int depth);
    return $clog2(lanes * depth + 1);
  endfunction

  // Lane pointer; a single lane still needs one bit of storage.
  function automatic int PTR_W(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Rotation counter, counts 0..DEPTH-1.
  function automatic int ROT_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/x_window_buffer_if.sv
// Input stream handshake between the upstream source and the window buffer.
interface x_window_buffer_if #(
  parameter int DATA_W = 8
) ();
  logic              load_en;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output load_en,
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  load_en,
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/x_window_buffer_shreg.sv
// One lane of the window: serial load shifts new data into the LSBs,
// rotation moves the oldest element (MSBs) back around to the LSBs.
module x_lane_shreg #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    rot,
  input  logic [DATA_W-1:0]       in_data,
  output logic [DEPTH*DATA_W-1:0] lane
);
  localparam int LW = DEPTH * DATA_W;

  logic [LW-1:0] lane_q;
  logic [LW-1:0] lane_d;

  // Clear beats rotate beats load; rotate and load never coincide since
  // the top level only issues each in its own state.
  always_comb begin
    lane_d = lane_q;
    if (clr) begin
      lane_d = '0;
    end else if (rot) begin
      lane_d = {lane_q[LW-DATA_W-1:0], lane_q[LW-1 -: DATA_W]};
    end else if (load) begin
      lane_d = {lane_q[LW-DATA_W-1:0], in_data};
    end
  end

  // Lane storage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign lane = lane_q;

endmodule

// File: rtl/x_window_buffer.sv
// Multi-lane X-operand window buffer: round-robin byte-serial fill into
// LANES shift-register lanes, then in-place circular rotation on request.
module x_window_buffer
  import x_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  x_window_buffer_if.slave              s_if,
  input  logic                          shift,
  input  logic                          clear,
  output logic [LANES*DEPTH*DATA_W-1:0] x_lanes,
  output logic                          full,
  output logic                          load_done,
  output logic [ROT_W(DEPTH)-1:0]       rot_count,
  output logic                          rot_wrap
);
  localparam int CW = CNT_W(LANES, DEPTH);
  localparam int PW = PTR_W(LANES);
  localparam int RW = ROT_W(DEPTH);
  localparam int LW = DEPTH * DATA_W;

  localparam logic [0:0] S_LOAD = ST_LOAD;
  localparam logic [0:0] S_FULL = ST_FULL;

  localparam logic [CW-1:0] CNT_LAST = CW'(LANES * DEPTH - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(LANES * DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(LANES - 1);
  localparam logic [RW-1:0] ROT_LAST = RW'(DEPTH - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] rot_q, rot_d;
  logic          load_done_q, load_done_d;
  logic          rot_wrap_q, rot_wrap_d;

  logic             in_ready;
  logic             accept;
  logic             do_rot;
  logic [LANES-1:0] lane_load;

  // Handshake decode: ready depends only on state and load_en, never on valid.
  always_comb begin
    in_ready = (state_q == S_LOAD) && s_if.load_en;
    accept   = s_if.in_valid && in_ready;
    do_rot   = (state_q == S_FULL) && shift && !clear;
  end

  assign s_if.in_ready = in_ready;

  // Route an accepted element to the lane under the pointer; a same-cycle
  // clear drops it.
  always_comb begin
    lane_load = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_load[k] = accept && !clear && (ptr_q == PW'(k));
    end
  end

  // FSM, element counter, lane pointer and rotation counter next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rot_d       = rot_q;
    load_done_d = 1'b0;
    rot_wrap_d  = 1'b0;
    if (clear) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      ptr_d   = '0;
      rot_d   = '0;
    end else if (accept) begin
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d     = S_FULL;
        load_done_d = 1'b1;
      end
    end else if (do_rot) begin
      rot_d      = (rot_q == ROT_LAST) ? '0 : rot_q + 1'b1;
      rot_wrap_d = (rot_q == ROT_LAST);
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rot_q       <= '0;
      load_done_q <= 1'b0;
      rot_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rot_q       <= rot_d;
      load_done_q <= load_done_d;
      rot_wrap_q  <= rot_wrap_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    x_lane_shreg #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clear),
      .load    (lane_load[k]),
      .rot     (do_rot),
      .in_data (s_if.in_data),
      .lane    (x_lanes[k*LW +: LW])
    );
  end

  assign full      = (state_q == S_FULL);
  assign load_done = load_done_q;
  assign rot_count = rot_q;
  assign rot_wrap  = rot_wrap_q;

endmodule

// File: tb/tb_x_window_buffer.sv
// Directed self-checking bench for x_window_buffer at W=8, L=4, D=8.
module tb_x_window_buffer;
  localparam int DW = 8;
  localparam int NL = 4;
  localparam int ND = 8;
  localparam int LW = ND * DW;
  localparam int XW = NL * LW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          shift = 1'b0;
  logic          clear = 1'b0;
  logic [XW-1:0] x_lanes;
  logic          full;
  logic          load_done;
  logic [2:0]    rot_count;
  logic          rot_wrap;

  int total = 0;
  int bad   = 0;

  x_window_buffer_if #(.DATA_W(DW)) bus ();

  x_window_buffer #(
    .DATA_W (DW),
    .LANES  (NL),
    .DEPTH  (ND)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_if      (bus.slave),
    .shift     (shift),
    .clear     (clear),
    .x_lanes   (x_lanes),
    .full      (full),
    .load_done (load_done),
    .rot_count (rot_count),
    .rot_wrap  (rot_wrap)
  );

  always #5 clk = ~clk;

  // Expected window after elements 0..n-1 were loaded round-robin.
  function automatic logic [XW-1:0] exp_lanes(input int n);
    logic [LW-1:0] l [NL];
    logic [XW-1:0] v;
    for (int k = 0; k < NL; k++) l[k] = '0;
    for (int e = 0; e < n; e++) l[e % NL] = {l[e % NL][LW-DW-1:0], 8'(e)};
    for (int k = 0; k < NL; k++) v[k*LW +: LW] = l[k];
    return v;
  endfunction

  // Expected window after r left rotations of every lane.
  function automatic logic [XW-1:0] rot_lanes(input logic [XW-1:0] v, input int r);
    logic [LW-1:0] t;
    logic [XW-1:0] o;
    for (int k = 0; k < NL; k++) begin
      t = v[k*LW +: LW];
      for (int i = 0; i < r; i++) t = {t[LW-DW-1:0], t[LW-1 -: DW]};
      o[k*LW +: LW] = t;
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    shift = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_all(output int pulses);
    pulses = 0;
    bus.load_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
      if (load_done) pulses++;
    end
    bus.in_valid = 1'b0;
    tick();
    if (load_done) pulses++;
  endtask

  task automatic test_reset();
    bus.load_en = 1'b1;
    apply_reset();
    total++; if (x_lanes !== '0) begin bad++; $display("FAIL reset_lanes got=%h want=0", x_lanes); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_load_done got=%b want=0", load_done); end
    total++; if (rot_count !== 3'd0) begin bad++; $display("FAIL reset_rot_count got=%0d want=0", rot_count); end
    total++; if (rot_wrap !== 1'b0) begin bad++; $display("FAIL reset_rot_wrap got=%b want=0", rot_wrap); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_fill();
    int pulses;
    apply_reset();
    pulses = 0;
    bus.load_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
      if (load_done) pulses++;
      if (i < 31) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_early_full i=%0d got=%b want=0", i, full); end
      end
    end
    bus.in_valid = 1'b0;
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL fill_load_done got=%b want=1", load_done); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", bus.in_ready); end
    total++; if (x_lanes[0 +: LW] !== 64'h0004080C1014181C) begin bad++; $display("FAIL fill_lane0 got=%h want=0004080c1014181c", x_lanes[0 +: LW]); end
    total++; if (x_lanes[3*LW +: LW] !== 64'h03070B0F13171B1F) begin bad++; $display("FAIL fill_lane3 got=%h want=03070b0f13171b1f", x_lanes[3*LW +: LW]); end
    total++; if (x_lanes !== exp_lanes(32)) begin bad++; $display("FAIL fill_all_lanes got=%h want=%h", x_lanes, exp_lanes(32)); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    tick();
    bus.in_valid = 1'b0;
    if (load_done) pulses++;
    total++; if (pulses != 1) begin bad++; $display("FAIL fill_pulse_count got=%0d want=1", pulses); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full_held got=%b want=1", full); end
    total++; if (x_lanes !== exp_lanes(32)) begin bad++; $display("FAIL fill_ignore_valid got=%h want=%h", x_lanes, exp_lanes(32)); end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    logic le;
    apply_reset();
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 300) begin
      le = !(cyc >= 8 && cyc <= 10);
      bus.load_en  = le;
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_data  = 8'(idx);
      @(negedge clk);
      total++; if (bus.in_ready !== le) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, le); end
      tick();
      if (le && bus.in_valid) idx++;
      total++; if (x_lanes !== exp_lanes(idx)) begin bad++; $display("FAIL bp_lanes cyc=%0d got=%h want=%h", cyc, x_lanes, exp_lanes(idx)); end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.load_en  = 1'b1;
    total++; if (idx != 32) begin bad++; $display("FAIL bp_timeout got=%0d want=32", idx); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL bp_full got=%b want=1", full); end
    total++; if (x_lanes !== exp_lanes(32)) begin bad++; $display("FAIL bp_final got=%h want=%h", x_lanes, exp_lanes(32)); end
  endtask

  task automatic test_rotate();
    int pulses;
    int wraps;
    apply_reset();
    fill_all(pulses);
    shift = 1'b1;
    tick();
    shift = 1'b0;
    total++; if (x_lanes[0 +: LW] !== 64'h04080C1014181C00) begin bad++; $display("FAIL rot1_lane0 got=%h want=04080c1014181c00", x_lanes[0 +: LW]); end
    total++; if (rot_count !== 3'd1) begin bad++; $display("FAIL rot1_count got=%0d want=1", rot_count); end
    total++; if (rot_wrap !== 1'b0) begin bad++; $display("FAIL rot1_wrap got=%b want=0", rot_wrap); end
    wraps = 0;
    shift = 1'b1;
    for (int s = 2; s <= 8; s++) begin
      tick();
      if (rot_wrap) wraps++;
      total++; if (rot_count !== 3'(s % 8)) begin bad++; $display("FAIL rot_count s=%0d got=%0d want=%0d", s, rot_count, s % 8); end
      total++; if (x_lanes !== rot_lanes(exp_lanes(32), s)) begin bad++; $display("FAIL rot_lanes s=%0d got=%h want=%h", s, x_lanes, rot_lanes(exp_lanes(32), s)); end
    end
    shift = 1'b0;
    tick();
    if (rot_wrap) wraps++;
    total++; if (wraps != 1) begin bad++; $display("FAIL rot_wrap_count got=%0d want=1", wraps); end
    total++; if (x_lanes !== exp_lanes(32)) begin bad++; $display("FAIL rot_restored got=%h want=%h", x_lanes, exp_lanes(32)); end
    total++; if (rot_count !== 3'd0) begin bad++; $display("FAIL rot_final_count got=%0d want=0", rot_count); end
  endtask

  task automatic test_shift_in_load();
    apply_reset();
    bus.load_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    shift = 1'b1;
    tick();
    tick();
    shift = 1'b0;
    total++; if (x_lanes !== exp_lanes(10)) begin bad++; $display("FAIL sil_lanes got=%h want=%h", x_lanes, exp_lanes(10)); end
    total++; if (rot_count !== 3'd0) begin bad++; $display("FAIL sil_rot_count got=%0d want=0", rot_count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL sil_full got=%b want=0", full); end
  endtask

  task automatic test_clear_priority();
    int pulses;
    apply_reset();
    fill_all(pulses);
    shift = 1'b1;
    tick();
    tick();
    tick();
    total++; if (rot_count !== 3'd3) begin bad++; $display("FAIL clr_pre_count got=%0d want=3", rot_count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    shift = 1'b0;
    total++; if (x_lanes !== '0) begin bad++; $display("FAIL clr_lanes got=%h want=0", x_lanes); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL clr_full got=%b want=0", full); end
    total++; if (rot_count !== 3'd0) begin bad++; $display("FAIL clr_rot_count got=%0d want=0", rot_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL clr_in_ready got=%b want=1", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    total++; if (x_lanes !== XW'(64'hA5)) begin bad++; $display("FAIL clr_next_lane0 got=%h want=a5 in lane0", x_lanes); end
    bus.in_data = 8'h5A;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (x_lanes !== '0) begin bad++; $display("FAIL clr_drop got=%h want=0", x_lanes); end
    bus.in_data = 8'h11;
    tick();
    bus.in_valid = 1'b0;
    total++; if (x_lanes !== XW'(64'h11)) begin bad++; $display("FAIL clr_ptr_reset got=%h want=11 in lane0", x_lanes); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    apply_reset();
    bus.load_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
    end
    total++; if (x_lanes !== exp_lanes(17)) begin bad++; $display("FAIL rm_partial got=%h want=%h", x_lanes, exp_lanes(17)); end
    rst = 1'b1;
    tick();
    total++; if (x_lanes !== '0) begin bad++; $display("FAIL rm_lanes got=%h want=0", x_lanes); end
    total++; if (full !== 1'b0 || load_done !== 1'b0 || rot_wrap !== 1'b0) begin bad++; $display("FAIL rm_flags got=%b%b%b want=000", full, load_done, rot_wrap); end
    total++; if (rot_count !== 3'd0) begin bad++; $display("FAIL rm_rot_count got=%0d want=0", rot_count); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    fill_all(pulses);
    total++; if (x_lanes !== exp_lanes(32)) begin bad++; $display("FAIL rm_refill got=%h want=%h", x_lanes, exp_lanes(32)); end
    total++; if (pulses != 1) begin bad++; $display("FAIL rm_pulses got=%0d want=1", pulses); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL rm_full got=%b want=1", full); end
  endtask

  initial begin
    bus.load_en  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_fill();
    test_backpressure();
    test_rotate();
    test_shift_in_load();
    test_clear_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_window_buffer.md
# x_window_buffer

Parametrised multi-lane X-operand buffer. It accepts a byte-serial stream, distributes elements round-robin into `LANES` shift-register lanes of `DEPTH` elements each, and flags when the window is full. Once full, it can rotate every lane circularly by one element per request so the downstream MAC array sees successive alignments without reloading. It sits between the input stream interface and the MAC/controller datapath as the next generation of the fixed 4×64-bit X buffer.

## Interface
- `DATA_W`, 8: element width in bits.
- `LANES`, 4: number of lanes, ≥1.
- `DEPTH`, 8: elements per lane, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load_en` input 1: enables loading while in LOAD.
- `in_valid` input 1: `in_data` valid.
- `in_data` input DATA_W: element to load.
- `in_ready` output 1: buffer accepts `in_data` this cycle.
- `shift` input 1: rotate all lanes by one element (FULL only).
- `clear` input 1: empty the buffer and return to LOAD.
- `x_lanes` output LANES*DEPTH*DATA_W: lane k at `[k*DEPTH*DATA_W +: DEPTH*DATA_W]`.
- `full` output 1: level, high in FULL.
- `load_done` output 1: one-cycle pulse on entry to FULL.
- `rot_count` output clog2(DEPTH): rotations since fill, mod DEPTH.
- `rot_wrap` output 1: one-cycle pulse when `rot_count` wraps to 0.

## Operation
- States: LOAD, FULL. Reset puts the block in LOAD. All lanes reset to 0, the element counter to 0, the lane pointer to 0, and `rot_count` to 0. `full`, `load_done`, and `rot_wrap` reset to 0.
- LOAD: `in_ready = load_en`. An accept is `in_valid && in_ready`. On an accept, the lane at the pointer shifts in: `lane <= {lane[DEPTH*DATA_W-DATA_W-1:0], in_data}`. The newest element goes to the LSBs and the oldest ends up at the MSBs. The pointer then advances by 1 and wraps from LANES-1 to 0. The counter increments.
- On the accept with counter = LANES*DEPTH-1, the next state is FULL. The counter saturates at LANES*DEPTH.
- FULL: `in_ready = 0` and `in_valid` is ignored. `shift` rotates every lane left by one element simultaneously: `lane <= {lane[DEPTH*DATA_W-DATA_W-1:0], lane[DEPTH*DATA_W-1 -: DATA_W]}`. Each rotation increments `rot_count` mod DEPTH. When it wraps from DEPTH-1 to 0, `rot_wrap` pulses.
- `shift` in LOAD has no effect.
- `clear` in any state zeroes the lanes, counter, pointer, and `rot_count`, and moves to LOAD. If `clear` and `shift` arrive in the same cycle, `clear` wins. If `clear` and an accept arrive in the same cycle, `clear` wins and the element is dropped. `in_ready` is still high that cycle, so the upstream source must not assert `clear` with an in-flight element it needs kept.
- `rst` overrides everything, including mid-load and mid-rotation.

## Timing
- `in_ready` is combinational from state and `load_en`. It has no dependency on `in_valid`.
- Load latency: an element accepted at edge N is visible on `x_lanes` after edge N.
- `load_done` and `full` assert in the cycle after the final accept edge. `load_done` lasts exactly one cycle, and `full` stays high until `clear` or `rst`.
- A `shift` sampled at edge N is reflected in `x_lanes`, `rot_count`, and `rot_wrap` after edge N. Back-to-back shifts give one rotation per cycle.
- A full fill takes exactly LANES*DEPTH accept cycles. Stalls (`in_valid` or `load_en` low) insert idle cycles with state held.
- `clear` takes effect at the next edge, and `in_ready` may be high in the following cycle.

## Structure
- Package `x_buf_pkg` holds the state enum (LOAD, FULL) and the `CNT_W` / `PTR_W` / `ROT_W` width helper functions.
- Sub-module `x_lane_shreg` (params DATA_W, DEPTH) implements one lane. Its inputs are `load` (shift in external data) and `rot` (circular shift), plus `clr`. The top level instantiates LANES copies with a generate loop and keeps the FSM, counter, pointer, and rotation counter.

## Test plan
All scenarios use defaults W=8, L=4, D=8.
- Fill: send 0x00..0x1F with `load_en=1` and `in_valid=1` continuously. Required: lane0 = 0x0004080C1014181C and lane3 = 0x03070B0F13171B1F. `load_done` pulses once, the cycle after the 32nd accept, `full=1`, and `in_ready=0`.
- Backpressure: drop `load_en` for 3 cycles mid-fill and toggle `in_valid` randomly. Required: no accepts while `load_en=0`, and the final lane contents are identical to the Fill scenario.
- Rotate: after Fill, apply 1 shift. Required: lane0 = 0x04080C1014181C00 and `rot_count=1`. Then apply 7 more shifts back-to-back. Required: lanes equal the post-fill values, `rot_count=0`, and `rot_wrap` pulses exactly once.
- Shift during LOAD: assert `shift` at 10 elements loaded. Required: lanes unchanged and `rot_count` stays 0.
- Clear priority: in FULL, assert `clear` and `shift` together. Required: all lanes 0, state LOAD, `in_ready=1` the next cycle, and the next element lands in lane0.
- Reset mid-operation: pulse `rst` after 17 accepts, then refill 0x00..0x1F. Required: outputs 0 during reset, and the Fill scenario results are reproduced exactly.
